// File: rtl/branch_restore_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_restore_ctrl_pkg
// Shared types for the branch restore controller and the branch checkpoint
// buffer (bcb) it reads from.
//   BCB_idx_t      : checkpoint tag allocated at prediction time
//   BTB_info_t     : BTB state saved in a checkpoint, replayed to the predictor
//   BRU_resolve_t  : one backend branch resolution (default PC width)
// -----------------------------------------------------------------------------
package branch_restore_ctrl_pkg;

   localparam int BCB_ENTRIES              = 8;
   localparam int BCB_IDX_W                = $clog2(BCB_ENTRIES);
   localparam int BRU_PC_WIDTH             = 32;
   localparam int BRU_RESOLVE_FIFO_ENTRIES = 4;

   typedef logic [BCB_IDX_W-1:0] BCB_idx_t;

   typedef struct packed {
      logic [BRU_PC_WIDTH-1:0] target_PC;
      logic [1:0]              bht_ctr;
      logic                    is_call;
      logic                    is_ret;
   } BTB_info_t;

   typedef struct packed {
      BCB_idx_t                bcb_index;
      logic                    mispredict;
      logic                    taken;
      logic [BRU_PC_WIDTH-1:0] target_PC;
   } BRU_resolve_t;

endpackage

// File: rtl/branch_restore_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_restore_ctrl_if
// Bundles every non-clock signal of the restore controller:
//   resolve_*     : in-order branch resolutions from the backend (valid/ready)
//   restore_bcb_* : asynchronous read port into bcb
//   update_*      : predictor-update record (valid/ready)
//   fe_redirect_* : one-cycle front-end redirect pulse
//   flush_valid   : external flush (exception)
// modport slave  : the controller
// modport master : backend / bcb / predictor / front-end side
// -----------------------------------------------------------------------------
interface branch_restore_ctrl_if
   import branch_restore_ctrl_pkg::*;
#(
   parameter int PC_WIDTH = BRU_PC_WIDTH
) ();

   logic                resolve_valid;
   logic                resolve_ready;
   BCB_idx_t            resolve_bcb_index;
   logic                resolve_mispredict;
   logic                resolve_taken;
   logic [PC_WIDTH-1:0] resolve_target_PC;

   BCB_idx_t            restore_bcb_index;
   BTB_info_t           restore_bcb_info;

   logic                update_valid;
   logic                update_ready;
   BTB_info_t           update_info;
   logic                update_taken;
   logic                update_mispredict;

   logic                fe_redirect_valid;
   logic [PC_WIDTH-1:0] fe_redirect_PC;
   BCB_idx_t            fe_redirect_bcb_index;

   logic                flush_valid;

   modport slave (
      input  resolve_valid, resolve_bcb_index, resolve_mispredict,
             resolve_taken, resolve_target_PC, restore_bcb_info,
             update_ready, flush_valid,
      output resolve_ready, restore_bcb_index, update_valid, update_info,
             update_taken, update_mispredict, fe_redirect_valid,
             fe_redirect_PC, fe_redirect_bcb_index
   );

   modport master (
      output resolve_valid, resolve_bcb_index, resolve_mispredict,
             resolve_taken, resolve_target_PC, restore_bcb_info,
             update_ready, flush_valid,
      input  resolve_ready, restore_bcb_index, update_valid, update_info,
             update_taken, update_mispredict, fe_redirect_valid,
             fe_redirect_PC, fe_redirect_bcb_index
   );

endinterface

// File: rtl/branch_restore_ctrl_distram.sv
// -----------------------------------------------------------------------------
// distram_1rport_1wport
// Distributed RAM: one synchronous write port, one asynchronous read port.
// Contents are not reset; the owner tracks which entries are valid.
//   i_clk   : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data (combinational)
// -----------------------------------------------------------------------------
module distram_1rport_1wport #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [AW-1:0]    i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic [AW-1:0]    i_raddr,
   output logic [WIDTH-1:0] o_rdata
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/branch_restore_ctrl.sv
// -----------------------------------------------------------------------------
// branch_restore_ctrl
// Queues in-order branch resolutions, reads each one's checkpoint back out of
// bcb at the FIFO head, and emits a predictor-update record. A mispredict at
// the head also produces a one-cycle front-end redirect and squashes every
// younger (wrong-path) resolution.
//   CLK  : clock
//   nRST : asynchronous active-low reset
//   bus  : branch_restore_ctrl_if.slave (resolve, bcb read, update, redirect,
//          flush)
// -----------------------------------------------------------------------------
module branch_restore_ctrl
   import branch_restore_ctrl_pkg::*;
#(
   parameter int RESOLVE_FIFO_ENTRIES = BRU_RESOLVE_FIFO_ENTRIES,
   parameter int PC_WIDTH             = BRU_PC_WIDTH
) (
   input  logic                  CLK,
   input  logic                  nRST,
   branch_restore_ctrl_if.slave  bus
);

   localparam int N     = RESOLVE_FIFO_ENTRIES;
   localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

   // FIFO entry: BRU_resolve_t layout at this instance's PC width
   typedef struct packed {
      BCB_idx_t            bcb_index;
      logic                mispredict;
      logic                taken;
      logic [PC_WIDTH-1:0] target_PC;
   } resolve_entry_t;

   logic [PTR_W-1:0]    r_head;
   logic [PTR_W-1:0]    r_tail;
   logic                r_head_wrap;
   logic                r_tail_wrap;

   logic                r_upd_valid;
   BTB_info_t           r_upd_info;
   logic                r_upd_taken;
   logic                r_upd_mispredict;

   logic                r_redir_valid;
   logic [PC_WIDTH-1:0] r_redir_pc;
   BCB_idx_t            r_redir_idx;

   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_pop_mp;
   logic                w_enq;
   logic [PTR_W:0]      w_head_inc;
   logic [PTR_W:0]      w_tail_inc;
   resolve_entry_t      w_wr_entry;
   resolve_entry_t      w_head_entry;

   // Returns {wrap, ptr}; wraps explicitly at N-1 so non-power-of-2 depths work
   function automatic logic [PTR_W:0] f_ptr_inc(input logic [PTR_W-1:0] ptr,
                                                input logic             wrap);
      if (ptr == PTR_W'(N - 1)) begin
         return {~wrap, {PTR_W{1'b0}}};
      end
      return {wrap, ptr + 1'b1};
   endfunction

   assign w_head_inc = f_ptr_inc(r_head, r_head_wrap);
   assign w_tail_inc = f_ptr_inc(r_tail, r_tail_wrap);

   assign w_empty = (r_head == r_tail) && (r_head_wrap == r_tail_wrap);
   assign w_full  = (r_head == r_tail) && (r_head_wrap != r_tail_wrap);

   // Flush beats everything: nothing pops or enqueues in a flush cycle
   assign w_pop    = ~w_empty & (~r_upd_valid | bus.update_ready) & ~bus.flush_valid;
   assign w_pop_mp = w_pop & w_head_entry.mispredict;
   // A resolution arriving alongside a mispredict pop is younger, hence wrong-path
   assign w_enq    = bus.resolve_valid & ~w_full & ~w_pop_mp & ~bus.flush_valid;

   assign w_wr_entry.bcb_index  = bus.resolve_bcb_index;
   assign w_wr_entry.mispredict = bus.resolve_mispredict;
   assign w_wr_entry.taken      = bus.resolve_taken;
   assign w_wr_entry.target_PC  = bus.resolve_target_PC;

   distram_1rport_1wport #(
      .WIDTH ($bits(resolve_entry_t)),
      .DEPTH (N)
   ) u_fifo (
      .i_clk   (CLK),
      .i_we    (w_enq),
      .i_waddr (r_tail),
      .i_wdata (w_wr_entry),
      .i_raddr (r_head),
      .o_rdata (w_head_entry)
   );

   // Forced to 0 when empty so the read index is clean out of reset
   assign bus.restore_bcb_index = w_empty ? '0 : w_head_entry.bcb_index;
   assign bus.resolve_ready     = ~w_full;

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_head      <= '0;
         r_tail      <= '0;
         r_head_wrap <= 1'b0;
         r_tail_wrap <= 1'b0;
      end else if (bus.flush_valid) begin
         r_tail      <= r_head;
         r_tail_wrap <= r_head_wrap;
      end else begin
         if (w_pop) begin
            {r_head_wrap, r_head} <= w_head_inc;
         end
         // Mispredict: tail lands on the new head, discarding younger entries
         if (w_pop_mp) begin
            {r_tail_wrap, r_tail} <= w_head_inc;
         end else if (w_enq) begin
            {r_tail_wrap, r_tail} <= w_tail_inc;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_upd_valid      <= 1'b0;
         r_upd_info       <= '0;
         r_upd_taken      <= 1'b0;
         r_upd_mispredict <= 1'b0;
         r_redir_valid    <= 1'b0;
         r_redir_pc       <= '0;
         r_redir_idx      <= '0;
      end else if (bus.flush_valid) begin
         r_upd_valid   <= 1'b0;
         r_redir_valid <= 1'b0;
      end else begin
         if (w_pop) begin
            r_upd_valid      <= 1'b1;
            r_upd_info       <= bus.restore_bcb_info;
            r_upd_taken      <= w_head_entry.taken;
            r_upd_mispredict <= w_head_entry.mispredict;
         end else if (bus.update_ready) begin
            r_upd_valid <= 1'b0;
         end
         r_redir_valid <= w_pop_mp;
         if (w_pop_mp) begin
            r_redir_pc  <= w_head_entry.target_PC;
            r_redir_idx <= w_head_entry.bcb_index;
         end
      end
   end

   assign bus.update_valid          = r_upd_valid;
   assign bus.update_info           = r_upd_info;
   assign bus.update_taken          = r_upd_taken;
   assign bus.update_mispredict     = r_upd_mispredict;
   assign bus.fe_redirect_valid     = r_redir_valid;
   assign bus.fe_redirect_PC        = r_redir_pc;
   assign bus.fe_redirect_bcb_index = r_redir_idx;

endmodule

// File: tb/tb_branch_restore_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_restore_ctrl
// Directed bench for branch_restore_ctrl with a reference-model scoreboard for
// update records and redirect pulses, plus a behavioural bcb array.
// -----------------------------------------------------------------------------
module tb_branch_restore_ctrl;
   import branch_restore_ctrl_pkg::*;

   typedef struct packed {
      BTB_info_t info;
      logic      taken;
      logic      mp;
   } upd_t;

   typedef struct packed {
      logic [31:0] pc;
      BCB_idx_t    idx;
   } redir_t;

   logic CLK  = 1'b0;
   logic nRST = 1'b0;

   int checks = 0;
   int errors = 0;

   upd_t      exp_upd[$];
   redir_t    exp_redir[$];
   logic      wrong_path = 1'b0;
   int        accept_cnt = 0;
   int        redir_cnt  = 0;
   BTB_info_t bcb_mem [BCB_ENTRIES];

   branch_restore_ctrl_if #(.PC_WIDTH(32)) bus ();

   branch_restore_ctrl #(
      .RESOLVE_FIFO_ENTRIES (4),
      .PC_WIDTH             (32)
   ) dut (
      .CLK  (CLK),
      .nRST (nRST),
      .bus  (bus)
   );

   always #5 CLK = ~CLK;

   assign bus.restore_bcb_info = bcb_mem[bus.restore_bcb_index];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Monitor / scoreboard: everything sampled mid-cycle on the falling edge
   always @(negedge CLK) begin
      if (nRST) begin
         if (bus.flush_valid) begin
            exp_upd.delete();
            exp_redir.delete();
            wrong_path = 1'b0;
         end else begin
            if (bus.fe_redirect_valid) begin
               redir_cnt++;
               if (exp_redir.size() == 0) begin
                  chk("redir_unexpected", bus.fe_redirect_valid, 1'b0);
               end else begin
                  chk("redir_pc",  bus.fe_redirect_PC, exp_redir[0].pc);
                  chk("redir_idx", bus.fe_redirect_bcb_index, exp_redir[0].idx);
                  void'(exp_redir.pop_front());
               end
               wrong_path = 1'b0;
            end
            if (bus.update_valid) begin
               if (exp_upd.size() == 0) begin
                  chk("upd_unexpected", bus.update_valid, 1'b0);
               end else begin
                  chk("upd_info",  bus.update_info,       exp_upd[0].info);
                  chk("upd_taken", bus.update_taken,      exp_upd[0].taken);
                  chk("upd_mp",    bus.update_mispredict, exp_upd[0].mp);
                  if (bus.update_ready) begin
                     void'(exp_upd.pop_front());
                     accept_cnt++;
                  end
               end
            end
            if (bus.resolve_valid && bus.resolve_ready && !wrong_path) begin
               exp_upd.push_back({bcb_mem[bus.resolve_bcb_index], bus.resolve_taken,
                                  bus.resolve_mispredict});
               if (bus.resolve_mispredict) begin
                  exp_redir.push_back({bus.resolve_target_PC, bus.resolve_bcb_index});
                  wrong_path = 1'b1;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic send(input int idx, input logic mp, input logic tk, input logic [31:0] pc);
      bus.resolve_valid      = 1'b1;
      bus.resolve_bcb_index  = BCB_idx_t'(idx);
      bus.resolve_mispredict = mp;
      bus.resolve_taken      = tk;
      bus.resolve_target_PC  = pc;
      step(1);
      bus.resolve_valid      = 1'b0;
   endtask

   task automatic drain(input string tag);
      int k = 0;
      while ((exp_upd.size() != 0 || exp_redir.size() != 0 || bus.update_valid) && k < 50) begin
         step(1);
         k++;
      end
      chk({tag, "_drained"}, (k < 50), 1'b1);
   endtask

   initial begin
      int acc0;
      int red0;
      for (int i = 0; i < BCB_ENTRIES; i++) begin
         bcb_mem[i].target_PC = 32'hA000_0000 + 32'(i * 16);
         bcb_mem[i].bht_ctr   = 2'(i);
         bcb_mem[i].is_call   = i[0];
         bcb_mem[i].is_ret    = i[1];
      end
      bus.resolve_valid      = 1'b0;
      bus.resolve_bcb_index  = '0;
      bus.resolve_mispredict = 1'b0;
      bus.resolve_taken      = 1'b0;
      bus.resolve_target_PC  = '0;
      bus.update_ready       = 1'b0;
      bus.flush_valid        = 1'b0;

      #12;
      chk("rst_upd_valid",   bus.update_valid, 1'b0);
      chk("rst_redir_valid", bus.fe_redirect_valid, 1'b0);
      chk("rst_ready",       bus.resolve_ready, 1'b1);
      chk("rst_restore_idx", bus.restore_bcb_index, 3'd0);
      chk("rst_upd_info",    bus.update_info, '0);
      @(posedge CLK);
      #1 nRST = 1'b1;
      step(1);

      // 1: single resolve
      bus.update_ready = 1'b1;
      send(3, 1'b0, 1'b1, 32'h3000);
      chk("t1_restore_idx", bus.restore_bcb_index, 3'd3);
      chk("t1_valid_early", bus.update_valid, 1'b0);
      step(1);
      chk("t1_valid",  bus.update_valid, 1'b1);
      chk("t1_info",   bus.update_info, bcb_mem[3]);
      chk("t1_redir",  bus.fe_redirect_valid, 1'b0);
      step(1);
      chk("t1_valid_off", bus.update_valid, 1'b0);
      drain("t1");

      // 2: backpressure and in-order drain
      bus.update_ready = 1'b0;
      send(4, 1'b0, 1'b0, 32'h4000);
      send(5, 1'b0, 1'b1, 32'h5000);
      send(6, 1'b0, 1'b0, 32'h6000);
      send(7, 1'b0, 1'b1, 32'h7000);
      chk("t2_ready_4", bus.resolve_ready, 1'b1);
      chk("t2_hold_a",  bus.update_info, bcb_mem[4]);
      send(0, 1'b0, 1'b0, 32'h0100);
      chk("t2_ready_full", bus.resolve_ready, 1'b0);
      chk("t2_hold_b",     bus.update_info, bcb_mem[4]);
      chk("t2_hold_valid", bus.update_valid, 1'b1);
      bus.update_ready = 1'b1;
      step(1);
      chk("t2_ready_back", bus.resolve_ready, 1'b1);
      chk("t2_d5", bus.update_info, bcb_mem[5]);
      step(1);
      chk("t2_d6", bus.update_info, bcb_mem[6]);
      step(1);
      chk("t2_d7", bus.update_info, bcb_mem[7]);
      step(1);
      chk("t2_d0",  bus.update_info, bcb_mem[0]);
      chk("t2_dv0", bus.update_valid, 1'b1);
      step(1);
      chk("t2_empty", bus.update_valid, 1'b0);
      drain("t2");

      // 3: mispredict squashes younger queued entries
      bus.update_ready = 1'b0;
      send(6, 1'b0, 1'b0, 32'h6000);
      send(1, 1'b1, 1'b1, 32'h1000);
      send(2, 1'b0, 1'b0, 32'h2000);
      send(3, 1'b0, 1'b1, 32'h3000);
      acc0 = accept_cnt;
      red0 = redir_cnt;
      bus.update_ready = 1'b1;
      step(1);
      chk("t3_redir_pulse", bus.fe_redirect_valid, 1'b1);
      chk("t3_redir_pc",    bus.fe_redirect_PC, 32'h1000);
      chk("t3_redir_idx",   bus.fe_redirect_bcb_index, 3'd1);
      chk("t3_upd_info",    bus.update_info, bcb_mem[1]);
      chk("t3_upd_mp",      bus.update_mispredict, 1'b1);
      step(1);
      chk("t3_redir_once",  bus.fe_redirect_valid, 1'b0);
      chk("t3_no_younger",  bus.update_valid, 1'b0);
      step(3);
      drain("t3");
      chk("t3_accepts", accept_cnt - acc0, 2);
      chk("t3_redirs",  redir_cnt - red0, 1);

      // 4: mispredict pop with same-cycle enqueue
      send(5, 1'b1, 1'b0, 32'h5000);
      send(6, 1'b0, 1'b1, 32'h6000);
      chk("t4_redir", bus.fe_redirect_valid, 1'b1);
      chk("t4_pc",    bus.fe_redirect_PC, 32'h5000);
      chk("t4_empty", bus.restore_bcb_index, 3'd0);
      step(1);
      chk("t4_dropped", bus.update_valid, 1'b0);
      drain("t4");

      // 5: flush with a held record and two queued entries
      bus.update_ready = 1'b0;
      send(1, 1'b0, 1'b0, 32'h1100);
      send(2, 1'b1, 1'b1, 32'h2222);
      send(4, 1'b0, 1'b0, 32'h4400);
      chk("t5_pre_valid", bus.update_valid, 1'b1);
      bus.flush_valid = 1'b1;
      step(1);
      bus.flush_valid = 1'b0;
      chk("t5_valid", bus.update_valid, 1'b0);
      chk("t5_ready", bus.resolve_ready, 1'b1);
      chk("t5_redir", bus.fe_redirect_valid, 1'b0);
      chk("t5_idx",   bus.restore_bcb_index, 3'd0);
      step(1);
      chk("t5_redir_late", bus.fe_redirect_valid, 1'b0);
      chk("t5_still_empty", bus.update_valid, 1'b0);
      bus.update_ready = 1'b1;
      send(2, 1'b0, 1'b1, 32'h2000);
      step(1);
      chk("t5_after_info", bus.update_info, bcb_mem[2]);
      drain("t5");

      // 6: asynchronous reset mid-stream
      send(4, 1'b0, 1'b0, 32'h4000);
      send(5, 1'b0, 1'b1, 32'h5000);
      #2 nRST = 1'b0;
      exp_upd.delete();
      exp_redir.delete();
      wrong_path = 1'b0;
      #1;
      chk("t6_valid", bus.update_valid, 1'b0);
      chk("t6_info",  bus.update_info, '0);
      chk("t6_taken", bus.update_taken, 1'b0);
      chk("t6_redir", bus.fe_redirect_valid, 1'b0);
      chk("t6_idx",   bus.restore_bcb_index, 3'd0);
      chk("t6_ready", bus.resolve_ready, 1'b1);
      @(posedge CLK);
      #1 nRST = 1'b1;
      step(1);
      send(0, 1'b0, 1'b1, 32'h0200);
      chk("t6_restore_idx", bus.restore_bcb_index, 3'd0);
      chk("t6_valid_early", bus.update_valid, 1'b0);
      step(1);
      chk("t6_valid1", bus.update_valid, 1'b1);
      chk("t6_info1",  bus.update_info, bcb_mem[0]);
      chk("t6_redir1", bus.fe_redirect_valid, 1'b0);
      drain("t6");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
